// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor. Accepts two WIDTH-bit
//                operands over a valid/ready handshake, produces one
//                difference bit per clock (LSB first) through a full-subtractor
//                cell with a registered borrow, and reports the WIDTH-bit
//                difference plus final borrow with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    // Counter sized so it can hold WIDTH without wrapping
    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_handshake;
    logic               w_last;

    assign w_handshake = (r_state == c_IDLE) && start_valid;
    assign w_last      = (r_state == c_RUN) && (r_cnt == c_LAST);

    // Full-subtractor cell on the current LSB and the result register after shifting the new bit in
    always_comb begin
        w_d        = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
        w_br_next  = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
        w_res_next = r_res >> 1;
        w_res_next[WIDTH-1] = w_d;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH edges, DONE exactly one
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start_valid) w_state_next = c_RUN;
            c_RUN:   if (r_cnt == c_LAST) w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Output decode: ready only in IDLE, busy is its complement, done marks DONE
    always_comb begin
        start_ready = (r_state == c_IDLE);
        busy        = (r_state != c_IDLE);
        done        = (r_state == c_DONE);
    end

    // Datapath: operand load, serial shift, and result capture on the last RUN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res      <= '0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else if (w_handshake) begin
            r_a_sh <= a_in;
            r_b_sh <= b_in;
            r_br   <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == c_RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_res  <= w_res_next;
            r_br   <= w_br_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                diff_out   <= w_res_next;
                borrow_out <= w_br_next;
            end
        end
    end

endmodule
`default_nettype wire
